// File: rtl/vid_pkg.sv
// Shared video definitions: 640x480@60 timing, RGB332 pixel layout and colour expansion.
// Used by the scanout path and the VFD writer.
package vid_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int HCNT_W = 10;
  localparam int VCNT_W = 10;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;
  localparam int COL_W  = 8;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb888_t;

  typedef struct packed {
    logic frame_start;
    logic vsync;
    logic hsync;
    logic vblank;
    logic hblank;
  } vid_flags_t;

  localparam vid_flags_t FLAGS_RESET = '{
    frame_start: 1'b0,
    vsync:       1'b0,
    hsync:       1'b0,
    vblank:      1'b1,
    hblank:      1'b1
  };

  // Bit replication keeps full-scale codes at full scale (3'b111 -> 8'hFF).
  function automatic rgb888_t expand_rgb332(input rgb332_t p);
    rgb888_t c;
    c.r = {p.r, p.r, p.r[R_W-1 -: 2]};
    c.g = {p.g, p.g, p.g[G_W-1 -: 2]};
    c.b = {p.b, p.b, p.b, p.b};
    return c;
  endfunction

endpackage

// File: rtl/vid_timing.sv
// Horizontal/vertical raster counters with undelayed sync, blank and frame-boundary decodes.
module vid_timing
  import vid_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic clk_vid,
  input  logic reset_n,
  output logic hsync,
  output logic vsync,
  output logic hblank,
  output logic vblank,
  output logic frame_first,
  output logic frame_last
);

  localparam int H_TOT = H_ACT + H_FRONT + H_SW + H_BACK;
  localparam int V_TOT = V_ACT + V_FRONT + V_SW + V_BACK;

  localparam logic [HCNT_W-1:0] H_LAST      = HCNT_W'(H_TOT - 1);
  localparam logic [HCNT_W-1:0] H_BLANK_BEG = HCNT_W'(H_ACT);
  localparam logic [HCNT_W-1:0] H_SYNC_BEG  = HCNT_W'(H_ACT + H_FRONT);
  localparam logic [HCNT_W-1:0] H_SYNC_END  = HCNT_W'(H_ACT + H_FRONT + H_SW);

  localparam logic [VCNT_W-1:0] V_LAST      = VCNT_W'(V_TOT - 1);
  localparam logic [VCNT_W-1:0] V_BLANK_BEG = VCNT_W'(V_ACT);
  localparam logic [VCNT_W-1:0] V_SYNC_BEG  = VCNT_W'(V_ACT + V_FRONT);
  localparam logic [VCNT_W-1:0] V_SYNC_END  = VCNT_W'(V_ACT + V_FRONT + V_SW);

  logic [HCNT_W-1:0] hcnt_reg;
  logic [HCNT_W-1:0] hcnt_next;
  logic [VCNT_W-1:0] vcnt_reg;
  logic [VCNT_W-1:0] vcnt_next;
  logic              line_end;

  assign line_end = (hcnt_reg == H_LAST);

  // vcnt advances and wraps on the same edge that wraps hcnt.
  always_comb begin
    hcnt_next = hcnt_reg + HCNT_W'(1);
    vcnt_next = vcnt_reg;
    if (line_end) begin
      hcnt_next = '0;
      vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + VCNT_W'(1);
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else begin
      hcnt_reg <= hcnt_next;
      vcnt_reg <= vcnt_next;
    end
  end

  assign hblank      = (hcnt_reg >= H_BLANK_BEG);
  assign vblank      = (vcnt_reg >= V_BLANK_BEG);
  assign hsync       = (hcnt_reg >= H_SYNC_BEG) && (hcnt_reg < H_SYNC_END);
  assign vsync       = (vcnt_reg >= V_SYNC_BEG) && (vcnt_reg < V_SYNC_END);
  assign frame_first = (hcnt_reg == '0) && (vcnt_reg == '0);
  assign frame_last  = line_end && (vcnt_reg == V_LAST);

endmodule

// File: rtl/vram_scanout.sv
// VRAM scanout: running read address, two-stage flag/pixel pipeline and RGB332 -> RGB888 output.
module vram_scanout
  import vid_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  din,
  output logic              ce_pxl,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic [COL_W-1:0]  red,
  output logic [COL_W-1:0]  green,
  output logic [COL_W-1:0]  blue,
  output logic              frame_start
);

  localparam int                PIPE_DEPTH = 2;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(H_ACT * V_ACT - 1);

  logic       raw_hsync;
  logic       raw_vsync;
  logic       raw_hblank;
  logic       raw_vblank;
  logic       raw_frame_first;
  logic       raw_frame_last;
  logic       raw_active;
  vid_flags_t flags_raw;

  vid_timing #(
    .H_ACT   (H_ACT),
    .H_FRONT (H_FRONT),
    .H_SW    (H_SW),
    .H_BACK  (H_BACK),
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_SW    (V_SW),
    .V_BACK  (V_BACK)
  ) u_vid_timing (
    .clk_vid     (clk_vid),
    .reset_n     (reset_n),
    .hsync       (raw_hsync),
    .vsync       (raw_vsync),
    .hblank      (raw_hblank),
    .vblank      (raw_vblank),
    .frame_first (raw_frame_first),
    .frame_last  (raw_frame_last)
  );

  assign raw_active = !raw_hblank && !raw_vblank;
  assign flags_raw  = '{
    frame_start: raw_frame_first,
    vsync:       raw_vsync,
    hsync:       raw_hsync,
    vblank:      raw_vblank,
    hblank:      raw_hblank
  };

  // Stage 0: address tracks y*H_ACT+x by counting active pixels; the last pixel
  // of the frame does not increment so the address parks at ADDR_LAST through vblank.
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    addr_next = addr_reg;
    if (raw_frame_last) begin
      addr_next = '0;
    end else if (raw_active && (addr_reg != ADDR_LAST)) begin
      addr_next = addr_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= addr_next;
    end
  end

  assign addr = addr_reg;

  // Timing flags follow the pixel through both stages so they line up with RGB.
  vid_flags_t flag_pipe_reg [PIPE_DEPTH];

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        flag_pipe_reg[i] <= FLAGS_RESET;
      end
    end else begin
      flag_pipe_reg[0] <= flags_raw;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        flag_pipe_reg[i] <= flag_pipe_reg[i-1];
      end
    end
  end

  // Stage 1: din and en are consumed here; blanking forces zero so junk on din never propagates.
  logic    pix_blank_d1;
  rgb888_t pix_rgb;

  assign pix_blank_d1 = flag_pipe_reg[0].hblank || flag_pipe_reg[0].vblank;
  assign pix_rgb      = expand_rgb332(rgb332_t'(din));

  logic [COL_W-1:0] red_reg;
  logic [COL_W-1:0] green_reg;
  logic [COL_W-1:0] blue_reg;
  logic             ce_pxl_reg;

  // Stage 2: registered colour outputs.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      red_reg    <= '0;
      green_reg  <= '0;
      blue_reg   <= '0;
      ce_pxl_reg <= 1'b0;
    end else begin
      ce_pxl_reg <= 1'b1;
      if (pix_blank_d1 || !en) begin
        red_reg   <= '0;
        green_reg <= '0;
        blue_reg  <= '0;
      end else begin
        red_reg   <= pix_rgb.r;
        green_reg <= pix_rgb.g;
        blue_reg  <= pix_rgb.b;
      end
    end
  end

  assign red         = red_reg;
  assign green       = green_reg;
  assign blue        = blue_reg;
  assign ce_pxl      = ce_pxl_reg;
  assign hsync       = flag_pipe_reg[PIPE_DEPTH-1].hsync;
  assign vsync       = flag_pipe_reg[PIPE_DEPTH-1].vsync;
  assign hblank      = flag_pipe_reg[PIPE_DEPTH-1].hblank;
  assign vblank      = flag_pipe_reg[PIPE_DEPTH-1].vblank;
  assign frame_start = flag_pipe_reg[PIPE_DEPTH-1].frame_start;

endmodule
